// File: rtl/clk_div_pkg.sv
// Shared defaults, channel FSM states and the write-channel index width helper
// for the clock divider bank.
package clk_div_pkg;

  localparam int unsigned DFLT_N_CH   = 4;
  localparam int unsigned DFLT_CNT_W  = 32;
  localparam int unsigned DFLT_PERIOD = 20_000_000;
  localparam int unsigned DFLT_HIGH   = 10_000_000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  // Bits needed to address n channels, never less than one.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((w < 32) && ((32'd1 << w) < n)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: pending/active period and high-time pairs, a wrap counter
// and registered clock/tick outputs that line up with the counter value.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned      CNT_W      = DFLT_CNT_W,
  parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(DFLT_PERIOD),
  parameter logic [CNT_W-1:0] DEF_HIGH   = CNT_W'(DFLT_HIGH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_period_i,
  input  logic [CNT_W-1:0] wr_high_i,
  output logic             clk_out_o,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] pend_p_q, pend_p_d;
  logic [CNT_W-1:0] pend_h_q, pend_h_d;
  logic [CNT_W-1:0] act_p_q, act_p_d;
  logic [CNT_W-1:0] act_h_q, act_h_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             act_ok, pend_ok;

  assign act_ok  = (act_p_q >= MIN_PERIOD);
  assign pend_ok = (pend_p_q >= MIN_PERIOD);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      pend_p_q <= DEF_PERIOD;
      pend_h_q <= DEF_HIGH;
      act_p_q  <= DEF_PERIOD;
      act_h_q  <= DEF_HIGH;
      cnt_q    <= '0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_p_q <= pend_p_d;
      pend_h_q <= pend_h_d;
      act_p_q  <= act_p_d;
      act_h_q  <= act_h_d;
      cnt_q    <= cnt_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
    end
  end

  // Outputs are computed from the next counter and next active pair, so the
  // registered clock and tick describe the same cycle as the registered count.
  // Loads always take the registered pending pair; a write landing on the same
  // edge therefore waits for the following wrap or sync.
  always_comb begin
    pend_p_d = pend_p_q;
    pend_h_d = pend_h_q;
    state_d  = state_q;
    act_p_d  = act_p_q;
    act_h_d  = act_h_q;
    cnt_d    = '0;
    clk_d    = 1'b0;
    tick_d   = 1'b0;

    if (wr_i) begin
      pend_p_d = wr_period_i;
      pend_h_d = wr_high_i;
    end

    if (!en_i) begin
      state_d = ST_IDLE;
      act_p_d = pend_p_q;
      act_h_d = pend_h_q;
    end else if (sync_i) begin
      act_p_d = pend_p_q;
      act_h_d = pend_h_q;
      state_d = pend_ok ? ST_RUN : ST_IDLE;
      clk_d   = pend_ok && (pend_h_q != '0);
    end else if (!act_ok) begin
      state_d = ST_IDLE;
      act_p_d = pend_p_q;
      act_h_d = pend_h_q;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_RUN;
      clk_d   = (act_h_q != '0);
    end else if (cnt_q == (act_p_q - ONE)) begin
      act_p_d = pend_p_q;
      act_h_d = pend_h_q;
      state_d = pend_ok ? ST_RUN : ST_IDLE;
      clk_d   = pend_ok && (pend_h_q != '0);
      tick_d  = pend_ok;
    end else begin
      cnt_d = cnt_q + ONE;
      clk_d = (cnt_d < act_h_q);
    end
  end

  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of N_CH programmable clock dividers sharing one configuration port,
// a registered sync-edge detector that realigns all channels, and a status LED.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned      N_CH       = DFLT_N_CH,
  parameter int unsigned      CNT_W      = DFLT_CNT_W,
  parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(DFLT_PERIOD),
  parameter logic [CNT_W-1:0] DEF_HIGH   = CNT_W'(DFLT_HIGH)
) (
  input  logic                         CLK_SYS,
  input  logic                         CLK_RST,
  input  logic [N_CH-1:0]              ch_en,
  input  logic                         sync_in,
  input  logic                         wr_en,
  input  logic [idx_width(N_CH)-1:0]   wr_ch,
  input  logic [CNT_W-1:0]             wr_period,
  input  logic [CNT_W-1:0]             wr_high,
  output logic [N_CH-1:0]              clk_out,
  output logic [N_CH-1:0]              tick,
  output logic                         LED
);

  logic            sync_prev_q;
  logic            sync_pulse_q;
  logic            led_q;
  logic [N_CH-1:0] wr_sel;

  // The edge is registered, so channels realign one edge after it is seen;
  // holding sync_in high produces only the single pulse.
  always_ff @(posedge CLK_SYS) begin
    if (CLK_RST) begin
      sync_prev_q  <= 1'b0;
      sync_pulse_q <= 1'b0;
      led_q        <= 1'b1;
    end else begin
      sync_prev_q  <= sync_in;
      sync_pulse_q <= sync_in & ~sync_prev_q;
      led_q        <= ~clk_out[0];
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    // Indices at or beyond N_CH match no channel and are dropped here.
    assign wr_sel[i] = wr_en && (32'(wr_ch) == i);

    clk_div_ch #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_HIGH   (DEF_HIGH)
    ) u_ch (
      .clk_i       (CLK_SYS),
      .rst_i       (CLK_RST),
      .en_i        (ch_en[i]),
      .sync_i      (sync_pulse_q),
      .wr_i        (wr_sel[i]),
      .wr_period_i (wr_period),
      .wr_high_i   (wr_high),
      .clk_out_o   (clk_out[i]),
      .tick_o      (tick[i])
    );
  end

  assign LED = led_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: two-channel instance for most scenarios and a
// three-channel instance so an out-of-range channel index can be expressed.
module tb_clk_div_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ch_en;
  logic       sync_in;
  logic       wr_en;
  logic       wr_ch;
  logic [7:0] wr_period;
  logic [7:0] wr_high;
  logic [1:0] clk_out;
  logic [1:0] tick;
  logic       led;

  logic [2:0] ch_en3;
  logic       wr_en3;
  logic [1:0] wr_ch3;
  logic [2:0] clk_out3;
  logic [2:0] tick3;
  logic       led3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_div_bank #(.N_CH(2), .CNT_W(8), .DEF_PERIOD(8'd10), .DEF_HIGH(8'd5)) dut (
    .CLK_SYS(clk), .CLK_RST(rst), .ch_en(ch_en), .sync_in(sync_in),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_period(wr_period), .wr_high(wr_high),
    .clk_out(clk_out), .tick(tick), .LED(led)
  );

  clk_div_bank #(.N_CH(3), .CNT_W(8), .DEF_PERIOD(8'd10), .DEF_HIGH(8'd5)) dut3 (
    .CLK_SYS(clk), .CLK_RST(rst), .ch_en(ch_en3), .sync_in(sync_in),
    .wr_en(wr_en3), .wr_ch(wr_ch3), .wr_period(wr_period), .wr_high(wr_high),
    .clk_out(clk_out3), .tick(tick3), .LED(led3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input int ch);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (tick[ch] !== 1'b1 && n < 40);
    checks++;
    if (tick[ch] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wait_tick ch%0d: tick got %b, required 1 within 40 cycles", ch, tick[ch]);
    end
  endtask

  task automatic wait_tick3(input int ch);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (tick3[ch] !== 1'b1 && n < 40);
    checks++;
    if (tick3[ch] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wait_tick3 ch%0d: tick got %b, required 1 within 40 cycles", ch, tick3[ch]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ch_en = 2'b00;
    step();
    step();
    checks++;
    if ({clk_out, tick, led} !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL reset: clk_out/tick/LED got %b, required 00001", {clk_out, tick, led});
    end
    checks++;
    if ({clk_out3, tick3, led3} !== 7'b0000001) begin
      errors++;
      $display("[TB] FAIL reset3: clk_out/tick/LED got %b, required 0000001", {clk_out3, tick3, led3});
    end
  endtask

  // Shared by the post-reset scenarios: both channels and dut3 run 10/5 from cnt 0.
  task automatic check_default_run(input string name, input int cycles);
    logic e_c, e_t, prev;
    int c;
    prev = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      step();
      c = k % 10;
      e_c = (c < 5);
      e_t = (k > 0) && (c == 0);
      checks++;
      if ({clk_out, tick} !== {e_c, e_c, e_t, e_t}) begin
        errors++;
        $display("[TB] FAIL %s k=%0d: clk_out/tick got %b, required %b", name, k, {clk_out, tick}, {e_c, e_c, e_t, e_t});
      end
      checks++;
      if (led !== ~prev) begin
        errors++;
        $display("[TB] FAIL %s_led k=%0d: LED got %b, required %b", name, k, led, ~prev);
      end
      checks++;
      if ({clk_out3, tick3} !== {{3{e_c}}, {3{e_t}}}) begin
        errors++;
        $display("[TB] FAIL %s_dut3 k=%0d: clk_out/tick got %b, required %b", name, k, {clk_out3, tick3}, {{3{e_c}}, {3{e_t}}});
      end
      prev = e_c;
    end
  endtask

  task automatic test_basic();
    ch_en = 2'b11;
    rst = 1'b0;
    check_default_run("basic", 25);
  endtask

  task automatic test_write_mid();
    int c0, c1;
    logic e_c1, e_c0, e_t1, e_t0;
    wait_tick(1);
    repeat (3) step();
    wr_en = 1'b1; wr_ch = 1'b1; wr_period = 8'd4; wr_high = 8'd1;
    step();
    wr_en = 1'b0;
    for (int c = 4; c <= 9; c++) begin
      if (c > 4) step();
      checks++;
      if ({clk_out[1], tick[1]} !== {(c < 5), 1'b0}) begin
        errors++;
        $display("[TB] FAIL write_mid_old cnt=%0d: ch1 clk/tick got %b, required %b", c, {clk_out[1], tick[1]}, {(c < 5), 1'b0});
      end
    end
    for (int k = 0; k < 12; k++) begin
      step();
      c0 = k % 10;
      c1 = k % 4;
      e_c1 = (c1 == 0); e_t1 = (c1 == 0);
      e_c0 = (c0 < 5);  e_t0 = (c0 == 0);
      checks++;
      if ({clk_out, tick} !== {e_c1, e_c0, e_t1, e_t0}) begin
        errors++;
        $display("[TB] FAIL write_mid_new k=%0d: clk_out/tick got %b, required %b", k, {clk_out, tick}, {e_c1, e_c0, e_t1, e_t0});
      end
    end
  endtask

  task automatic check_sync_run(input string name, input int k);
    logic e_c1, e_c0, e_t1, e_t0;
    e_c1 = (k % 4 == 0); e_t1 = (k % 4 == 0);
    e_c0 = (k % 10 < 5); e_t0 = (k % 10 == 0);
    checks++;
    if ({clk_out, tick} !== {e_c1, e_c0, e_t1, e_t0}) begin
      errors++;
      $display("[TB] FAIL %s k=%0d: clk_out/tick got %b, required %b", name, k, {clk_out, tick}, {e_c1, e_c0, e_t1, e_t0});
    end
  endtask

  task automatic test_sync();
    wait_tick(0);
    repeat (6) step();
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    step();
    checks++;
    if ({clk_out, tick} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL sync_pulse: clk_out/tick got %b, required 1100", {clk_out, tick});
    end
    for (int k = 1; k <= 10; k++) begin
      step();
      check_sync_run("sync_after", k);
    end
    sync_in = 1'b1;
    step();
    step();
    checks++;
    if ({clk_out, tick} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL sync_hold_align: clk_out/tick got %b, required 1100", {clk_out, tick});
    end
    for (int j = 1; j <= 18; j++) begin
      step();
      check_sync_run("sync_hold", j);
    end
    sync_in = 1'b0;
    wait_tick(0);
    repeat (8) step();
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    step();
    checks++;
    if ({clk_out, tick} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL sync_at_wrap: clk_out/tick got %b, required 1100", {clk_out, tick});
    end
  endtask

  task automatic test_short_period();
    wait_tick(0);
    wr_en = 1'b1; wr_ch = 1'b0; wr_period = 8'd1; wr_high = 8'd0;
    step();
    wr_en = 1'b0;
    for (int c = 2; c <= 9; c++) begin
      step();
      checks++;
      if ({clk_out[0], tick[0]} !== {(c < 5), 1'b0}) begin
        errors++;
        $display("[TB] FAIL p1_before cnt=%0d: ch0 clk/tick got %b, required %b", c, {clk_out[0], tick[0]}, {(c < 5), 1'b0});
      end
    end
    for (int n = 0; n < 6; n++) begin
      step();
      checks++;
      if ({clk_out[0], tick[0]} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL p1_after n=%0d: ch0 clk/tick got %b, required 00", n, {clk_out[0], tick[0]});
      end
    end
    wr_en = 1'b1; wr_ch = 1'b0; wr_period = 8'd6; wr_high = 8'd6;
    step();
    wr_en = 1'b0;
    step();
    checks++;
    if ({clk_out[0], tick[0]} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL p6_load: ch0 clk/tick got %b, required 00", {clk_out[0], tick[0]});
    end
    step();
    checks++;
    if ({clk_out[0], tick[0]} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL p6_start: ch0 clk/tick got %b, required 10", {clk_out[0], tick[0]});
    end
    for (int k = 1; k <= 13; k++) begin
      step();
      checks++;
      if ({clk_out[0], tick[0]} !== {1'b1, (k % 6 == 0)}) begin
        errors++;
        $display("[TB] FAIL p6_run k=%0d: ch0 clk/tick got %b, required %b", k, {clk_out[0], tick[0]}, {1'b1, (k % 6 == 0)});
      end
    end
  endtask

  task automatic test_wrap_write();
    int c;
    wait_tick(1);
    repeat (3) step();
    wr_en = 1'b1; wr_ch = 1'b1; wr_period = 8'd3; wr_high = 8'd2;
    step();
    wr_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      checks++;
      if ({clk_out[1], tick[1]} !== {(k == 0), (k == 0)}) begin
        errors++;
        $display("[TB] FAIL wrap_write_old k=%0d: ch1 clk/tick got %b, required %b", k, {clk_out[1], tick[1]}, {(k == 0), (k == 0)});
      end
    end
    for (int m = 0; m < 9; m++) begin
      step();
      c = m % 3;
      checks++;
      if ({clk_out[1], tick[1]} !== {(c < 2), (c == 0)}) begin
        errors++;
        $display("[TB] FAIL wrap_write_new m=%0d: ch1 clk/tick got %b, required %b", m, {clk_out[1], tick[1]}, {(c < 2), (c == 0)});
      end
    end
    wait_tick3(2);
    wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_period = 8'd4; wr_high = 8'd1;
    step();
    wr_en3 = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      if (k > 1) step();
      c = k % 10;
      checks++;
      if ({clk_out3, tick3} !== {{3{(c < 5)}}, {3{(c == 0)}}}) begin
        errors++;
        $display("[TB] FAIL bad_ch k=%0d: dut3 clk_out/tick got %b, required %b", k, {clk_out3, tick3}, {{3{(c < 5)}}, {3{(c == 0)}}});
      end
    end
  endtask

  task automatic test_enable();
    int c;
    ch_en = 2'b01;
    for (int n = 0; n < 5; n++) begin
      step();
      checks++;
      if ({clk_out[1], tick[1]} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL disabled n=%0d: ch1 clk/tick got %b, required 00", n, {clk_out[1], tick[1]});
      end
    end
    ch_en = 2'b11;
    step();
    checks++;
    if ({clk_out[1], tick[1]} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL enable_first: ch1 clk/tick got %b, required 10", {clk_out[1], tick[1]});
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      c = k % 3;
      checks++;
      if ({clk_out[1], tick[1]} !== {(c < 2), (c == 0)}) begin
        errors++;
        $display("[TB] FAIL enable_run k=%0d: ch1 clk/tick got %b, required %b", k, {clk_out[1], tick[1]}, {(c < 2), (c == 0)});
      end
    end
  endtask

  task automatic test_reset_mid();
    repeat (2) step();
    wr_en = 1'b1; wr_ch = 1'b1; wr_period = 8'd7; wr_high = 8'd3;
    step();
    wr_en = 1'b0;
    step();
    rst = 1'b1;
    wr_en = 1'b1; wr_ch = 1'b0; wr_period = 8'd3; wr_high = 8'd1;
    sync_in = 1'b1;
    step();
    checks++;
    if ({clk_out, tick, led} !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL reset_mid: clk_out/tick/LED got %b, required 00001", {clk_out, tick, led});
    end
    rst = 1'b0;
    wr_en = 1'b0;
    sync_in = 1'b0;
    check_default_run("reset_mid_run", 21);
  endtask

  initial begin
    rst = 1'b1; ch_en = 2'b00; sync_in = 1'b0;
    wr_en = 1'b0; wr_ch = 1'b0; wr_period = 8'd0; wr_high = 8'd0;
    ch_en3 = 3'b111; wr_en3 = 1'b0; wr_ch3 = 2'd0;
    #1;
    test_reset();
    test_basic();
    test_write_mid();
    test_sync();
    test_short_period();
    test_wrap_write();
    test_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter N_CH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 32, counter/period/high-time width in bits.
REQ-003 Parameter DEF_PERIOD, default 20_000_000, per-channel period loaded at reset.
REQ-004 Parameter DEF_HIGH, default 10_000_000, per-channel high time loaded at reset.
REQ-005 CLK_SYS  input  1  system clock; all logic on its rising edge.
REQ-006 CLK_RST  input  1  reset, synchronous, active-high.
REQ-007 ch_en  input  N_CH  per-channel enable.
REQ-008 sync_in  input  1  external alignment pulse (e.g. PPS), already synchronous to CLK_SYS.
REQ-009 wr_en  input  1  configuration write strobe, one write per asserted cycle.
REQ-010 wr_ch  input  clog2(N_CH) (min 1)  target channel of write.
REQ-011 wr_period  input  CNT_W  new period P in cycles.
REQ-012 wr_high  input  CNT_W  new high time H in cycles.
REQ-013 clk_out  output  N_CH  registered divided clock per channel.
REQ-014 tick  output  N_CH  one-cycle pulse per channel at natural wrap.
REQ-015 LED  output  1  registered copy of clk_out[0], inverted (LED high during low phase).

Function
REQ-016 Each channel SHALL hold a pending (P,H) pair and an active (P,H) pair plus counter cnt, all CNT_W bits.
REQ-017 A write with wr_en=1 and wr_ch<N_CH SHALL update that channel's pending pair at the next edge; wr_ch>=N_CH SHALL be ignored.
REQ-018 Enabled channel with active P>=2: cnt SHALL count 0..P-1 and wrap to 0, one step per cycle.
REQ-019 At wrap (cnt==P-1) the active pair SHALL be loaded from pending; a write in the same cycle as wrap SHALL take effect at the following wrap.
REQ-020 clk_out[i] SHALL be registered so that clk_out[i]==(cnt<H_active) in the same cycle as cnt; H=0 gives constant 0, H>=P constant 1.
REQ-021 tick[i] SHALL be 1 exactly in cycles where cnt==0 as a result of a natural wrap; never on reset, sync or enable.
REQ-022 Channel with ch_en=0 or active P<2: cnt SHALL be held 0, clk_out=0, tick=0, active pair SHALL continuously follow pending.
REQ-023 Enable rising: first enabled cycle SHALL show cnt==0 with clk_out==(0<H).
REQ-024 sync_in rising edge (registered edge detect, sync_in=1 with previous sample 0) SHALL, at the following edge, force cnt=0 and load active from pending on all enabled channels.
REQ-025 Sync coinciding with wrap: sync behaviour SHALL apply and tick SHALL be 0.
REQ-026 Sync held high SHALL act once; sync with a write same cycle: the write SHALL not be part of that sync load.
REQ-027 Counter arithmetic SHALL be unsigned modulo 2^CNT_W; no output SHALL glitch (all outputs direct flop outputs).

Reset
REQ-028 CLK_RST=1 at an edge SHALL set cnt=0, active and pending pairs=(DEF_PERIOD,DEF_HIGH), clk_out=0, tick=0, LED=1, sync edge register=0.
REQ-029 Reset mid-period SHALL discard pending writes; first post-reset cycle counts from 0.
REQ-030 Reset SHALL override write, sync and enable in the same cycle.

Structure
REQ-031 Package clk_div_pkg SHALL hold default constants and the clog2 helper for wr_ch width.
REQ-032 Per-channel logic SHALL be sub-module clk_div_ch, instantiated N_CH times by generate; sync edge detect and LED stay in top level.

Verification (N_CH=2, CNT_W=8, DEF_PERIOD=10, DEF_HIGH=5)
REQ-033 Release reset, ch_en=11 -> clk_out[0] period 10 cycles, high 5, tick every 10 cycles at cnt==0, LED inverse of clk_out[0].
REQ-034 Write ch1 P=4 H=1 mid-period -> ch1 keeps 10/5 until its wrap, then 4/1; ch0 unaffected.
REQ-035 sync_in pulse at cnt0==6 -> two edges later both cnt==0, clk_out=1, no tick; hold sync_in 20 cycles -> single realignment.
REQ-036 Write ch0 P=1 -> after wrap clk_out[0]=0, tick[0]=0; write P=6 H=6 -> clk_out[0] constant 1, tick every 6.
REQ-037 Write exactly in wrap cycle, and write wr_ch=3 -> former applied one period later, latter no effect.
REQ-038 Assert CLK_RST for 1 cycle mid-period with pending write outstanding -> all state back to 10/5, cnt=0, LED=1.
